// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory port bundle for the load/store unit.
// Latency: none (wires only).
// Backpressure: req_ready gates requests; the memory side has no backpressure.
interface load_store_unit_if;
    // core request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    // core response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_err_code;
    // memory read port
    logic        mem_r_en;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data;
    // memory write port
    logic        mem_w_en;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic [4:0]  mem_w_strb;
    // memory status after an access
    logic [1:0]  mem_state;

    // Environment side: the core issuing requests and the memory answering them.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err_code,
        input  mem_r_en, mem_r_addr,
        output mem_r_data,
        input  mem_w_en, mem_w_addr, mem_w_data, mem_w_strb,
        output mem_state
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready,
        output resp_valid, resp_rdata, resp_err_code,
        output mem_r_en, mem_r_addr,
        input  mem_r_data,
        output mem_w_en, mem_w_addr, mem_w_data, mem_w_strb,
        input  mem_state
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: checks size/alignment/bounds, issues one aligned word access, extends load data.
// Latency: 2 cycles accept-to-response for legal accesses, 1 cycle for locally rejected ones.
// Backpressure: req_ready only in IDLE; requests seen while busy are dropped, clk_enable low freezes everything.
module load_store_unit #(
    parameter int MEMORY_SIZE_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_enable,
    load_store_unit_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [2:0] ERR_OK    = 3'b000;
    localparam logic [2:0] ERR_BOUND = 3'b010;
    localparam logic [2:0] ERR_ALIGN = 3'b011;
    localparam logic [2:0] ERR_SIZE  = 3'b100;

    localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE_WORDS);

    logic [1:0]  state;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [2:0]  lat_code;

    logic        illegal_size;
    logic        misaligned;
    logic        out_of_bounds;
    logic [2:0]  chk_code;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] ld_lane;
    logic [31:0] ld_ext;
    logic        accept;

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid && (state == ST_IDLE);

    // Request checks in priority order: size code, then alignment, then bounds.
    always_comb begin
        illegal_size  = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                        (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
        // H/HU share funct3[1:0]=01; W is 010 only once illegal codes are excluded
        misaligned    = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_bounds = ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS);
        chk_code      = ERR_OK;
        if (illegal_size)
            chk_code = ERR_SIZE;
        else if (misaligned)
            chk_code = ERR_ALIGN;
        else if (out_of_bounds)
            chk_code = ERR_BOUND;
    end

    // Store lane placement: replicate the right-aligned data across the word, strobe only the addressed bytes.
    always_comb begin
        st_data = bus.req_wdata;
        st_strb = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_data = {4{bus.req_wdata[7:0]}};
                st_strb = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                st_data = {2{bus.req_wdata[15:0]}};
                st_strb = 4'b0011 << {bus.req_addr[1], 1'b0};
            end
            default: begin
                st_data = bus.req_wdata;
                st_strb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the latched size code and byte offset.
    always_comb begin
        ld_lane = bus.mem_r_data >> {lat_off, 3'b000};
        case (lat_funct3)
            3'b000:  ld_ext = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'b001:  ld_ext = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'b100:  ld_ext = {24'h000000, ld_lane[7:0]};
            3'b101:  ld_ext = {16'h0000, ld_lane[15:0]};
            default: ld_ext = ld_lane;
        endcase
    end

    // Main sequencer: accept, issue one registered memory access, collect status, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            lat_we            <= 1'b0;
            lat_funct3        <= 3'b000;
            lat_off           <= 2'b00;
            lat_code          <= ERR_OK;
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= 32'h0;
            bus.resp_err_code <= ERR_OK;
            bus.mem_r_en      <= 1'b0;
            bus.mem_r_addr    <= 32'h0;
            bus.mem_w_en      <= 1'b0;
            bus.mem_w_addr    <= 32'h0;
            bus.mem_w_data    <= 32'h0;
            bus.mem_w_strb    <= 5'b00000;
        end else if (clk_enable) begin
            // response is a single-cycle pulse unless re-raised below
            bus.resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we     <= bus.req_we;
                        lat_funct3 <= bus.req_funct3;
                        lat_off    <= bus.req_addr[1:0];
                        lat_code   <= chk_code;
                        if (chk_code != ERR_OK) begin
                            state <= ST_ERR;
                        end else begin
                            state <= ST_ISSUE;
                            if (bus.req_we) begin
                                bus.mem_w_en   <= 1'b1;
                                bus.mem_w_addr <= {bus.req_addr[31:2], 2'b00};
                                bus.mem_w_data <= st_data;
                                bus.mem_w_strb <= {1'b0, st_strb};
                            end else begin
                                bus.mem_r_en   <= 1'b1;
                                bus.mem_r_addr <= {bus.req_addr[31:2], 2'b00};
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    // memory samples on this edge; enables are single-cycle
                    bus.mem_r_en <= 1'b0;
                    bus.mem_w_en <= 1'b0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    state          <= ST_IDLE;
                    bus.resp_valid <= 1'b1;
                    if (bus.mem_state != 2'b00) begin
                        bus.resp_err_code <= {1'b0, bus.mem_state};
                        bus.resp_rdata    <= 32'h0;
                    end else begin
                        bus.resp_err_code <= ERR_OK;
                        bus.resp_rdata    <= lat_we ? 32'h0 : ld_ext;
                    end
                end
                default: begin
                    state             <= ST_IDLE;
                    bus.resp_valid    <= 1'b1;
                    bus.resp_err_code <= lat_code;
                    bus.resp_rdata    <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic against a byte-level model.
// Latency: checks 2-cycle legal and 1-cycle rejected response timing, plus clk_enable stalls.
// Backpressure: drives requests while busy to confirm they are ignored.
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    logic clk_enable;

    load_store_unit_if bus ();

    load_store_unit #(.MEMORY_SIZE_WORDS(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory stub that serves the DUT (word array, strobe-based writes)
    logic [31:0] stub_mem [0:1023];
    logic [1:0]  fault_state;

    // reference model of memory contents, byte addressed
    logic [7:0]  ref_mem [0:4095];

    int n_cmp;
    int n_err;

    int          cap_lat;
    logic [31:0] cap_w_addr;
    logic [31:0] cap_w_data;
    logic [4:0]  cap_w_strb;
    int          cap_rcnt;

    // Memory stub: one access per enabled edge, status reported alongside the data.
    always @(posedge clk) begin
        if (clk_enable) begin
            if (bus.mem_w_en) begin
                for (int k = 0; k < 4; k++)
                    if (bus.mem_w_strb[k])
                        stub_mem[bus.mem_w_addr[11:2]][8*k +: 8] <= bus.mem_w_data[8*k +: 8];
                bus.mem_state <= fault_state;
            end
            if (bus.mem_r_en) begin
                bus.mem_r_data <= stub_mem[bus.mem_r_addr[11:2]];
                bus.mem_state  <= fault_state;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction: drive, watch the memory ports, compare with the model's prediction.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [1:0] fault, input int stall,
                           input bit garbage, input bit hold_chk);
        int          sz;
        int          off;
        bit          local_err;
        logic [2:0]  exp_code;
        logic [31:0] exp_data;
        logic [31:0] exp_wdat;
        logic [3:0]  exp_strb;
        int          exp_lat;
        int          n;
        int          rcnt;
        int          wcnt;
        int          both;
        int          stall_left;
        bit          got;

        sz  = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        off = int'(addr % 4);
        local_err = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2]))
            exp_code = 3'b100;
        else if (addr % sz != 0)
            exp_code = 3'b011;
        else if (addr / 4 >= 1024)
            exp_code = 3'b010;
        else begin
            local_err = 1'b0;
            exp_code  = {1'b0, fault};
        end
        exp_lat = local_err ? 1 : 2 + stall;

        exp_data = 32'h0;
        if (!we && !local_err && fault == 2'b00) begin
            for (int i = 0; i < sz; i++)
                exp_data = exp_data | (32'(ref_mem[addr + i]) << (8 * i));
            if (!f3[2] && sz == 1 && exp_data[7])  exp_data = exp_data | 32'hFFFF_FF00;
            if (!f3[2] && sz == 2 && exp_data[15]) exp_data = exp_data | 32'hFFFF_0000;
        end

        exp_strb = 4'b0000;
        exp_wdat = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k >= off && k < off + sz) exp_strb[k] = 1'b1;
            exp_wdat[8*k +: 8] = wdata[8*(k % sz) +: 8];
        end

        fault_state = fault;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
        @(posedge clk);

        n = 0; rcnt = 0; wcnt = 0; both = 0; got = 1'b0; stall_left = stall;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (bus.mem_r_en) rcnt++;
            if (bus.mem_w_en) wcnt++;
            if (bus.mem_r_en && bus.mem_w_en) both++;
            if (n == 1 && !local_err && we) begin
                cap_w_addr = bus.mem_w_addr;
                cap_w_data = bus.mem_w_data;
                cap_w_strb = bus.mem_w_strb;
                chk("w_addr", bus.mem_w_addr, {addr[31:2], 2'b00});
                chk("w_data", bus.mem_w_data, exp_wdat);
                chk("w_strb", 32'(bus.mem_w_strb), 32'(exp_strb));
            end
            if (n == 1 && !local_err && !we)
                chk("r_addr", bus.mem_r_addr, {addr[31:2], 2'b00});
            if (bus.resp_valid) begin
                got = 1'b1;
                bus.req_valid = 1'b0;
            end else if (garbage) begin
                // busy-time requests must not be accepted
                bus.req_valid  = 1'($urandom % 2);
                bus.req_we     = 1'($urandom % 2);
                bus.req_addr   = $urandom_range(0, 4095) & 32'hFFFF_FFFC;
                bus.req_wdata  = $urandom;
                bus.req_funct3 = 3'b010;
            end else begin
                bus.req_valid = 1'b0;
            end
            if (!got && !local_err && n >= 2 && stall_left > 0) begin
                clk_enable = 1'b0;
                stall_left--;
            end else begin
                clk_enable = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        clk_enable    = 1'b1;
        cap_lat  = n - 1;
        cap_rcnt = rcnt;

        chk("resp_seen", 32'(got), 32'd1);
        chk("latency", 32'(n - 1), 32'(exp_lat));
        chk("err_code", 32'(bus.resp_err_code), 32'(exp_code));
        chk("rdata", bus.resp_rdata, exp_data);
        chk("r_en_count", 32'(rcnt), (!local_err && !we) ? 32'd1 : 32'd0);
        chk("w_en_count", 32'(wcnt), (!local_err && we) ? 32'd1 : 32'd0);
        chk("both_en", 32'(both), 32'd0);

        if (hold_chk) begin
            clk_enable = 1'b0;
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rdata", bus.resp_rdata, exp_data);
            clk_enable = 1'b1;
        end
        @(negedge clk);
        chk("valid_pulse", 32'(bus.resp_valid), 32'd0);

        if (we && !local_err && fault == 2'b00)
            for (int i = 0; i < sz; i++)
                ref_mem[addr + i] = wdata[8*i +: 8];
    endtask

    initial begin
        bit          seen;
        logic        r_we;
        logic [31:0] r_addr;
        logic [2:0]  r_f3;
        logic [1:0]  r_fault;
        logic [31:0] w;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clk_enable = 1'b1;
        fault_state = 2'b00;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_funct3 = 3'b000;
        bus.mem_r_data = 32'h0;
        bus.mem_state = 2'b00;

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (i == 4) w = 32'h8081_F2A3;
            stub_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end

        // reset state
        #12;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_code", 32'(bus.resp_err_code), 32'd0);
        chk("rst_r_en", 32'(bus.mem_r_en), 32'd0);
        chk("rst_w_en", 32'(bus.mem_w_en), 32'd0);
        chk("rst_w_strb", 32'(bus.mem_w_strb), 32'd0);
        chk("rst_w_data", bus.mem_w_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed loads from word[4]
        run_txn(1'b0, 32'h10, 32'h0, 3'b000, 2'b00, 0, 1'b0, 1'b0);
        chk("lb_lat", 32'(cap_lat), 32'd2);
        chk("lb_data", bus.resp_rdata, 32'hFFFF_FFA3);
        run_txn(1'b0, 32'h13, 32'h0, 3'b100, 2'b00, 0, 1'b0, 1'b0);
        chk("lbu_data", bus.resp_rdata, 32'h0000_0080);
        run_txn(1'b0, 32'h12, 32'h0, 3'b001, 2'b00, 0, 1'b0, 1'b0);
        chk("lh_data", bus.resp_rdata, 32'hFFFF_8081);
        run_txn(1'b0, 32'h10, 32'h0, 3'b101, 2'b00, 0, 1'b0, 1'b0);
        chk("lhu_data", bus.resp_rdata, 32'h0000_F2A3);

        // byte store into lane 2
        run_txn(1'b1, 32'h0E, 32'h0000_0055, 3'b000, 2'b00, 0, 1'b0, 1'b0);
        chk("sb_w_addr", cap_w_addr, 32'h0000_000C);
        chk("sb_w_data", cap_w_data, 32'h5555_5555);
        chk("sb_w_strb", 32'(cap_w_strb), 32'b00100);
        chk("sb_no_read", 32'(cap_rcnt), 32'd0);

        // locally rejected accesses
        run_txn(1'b0, 32'h02, 32'h0, 3'b010, 2'b00, 0, 1'b0, 1'b0);
        chk("lw_mis_code", 32'(bus.resp_err_code), 32'b011);
        run_txn(1'b0, 32'h1001, 32'h0, 3'b001, 2'b00, 0, 1'b0, 1'b0);
        chk("lh_mis_code", 32'(bus.resp_err_code), 32'b011);
        run_txn(1'b0, 32'h1000, 32'h0, 3'b010, 2'b00, 0, 1'b0, 1'b0);
        chk("lw_oob_code", 32'(bus.resp_err_code), 32'b010);
        run_txn(1'b0, 32'h20, 32'h0, 3'b011, 2'b00, 0, 1'b0, 1'b0);
        chk("f3_ill_code", 32'(bus.resp_err_code), 32'b100);
        chk("f3_ill_lat", 32'(cap_lat), 32'd1);

        // memory fault, then a stalled load with the response held
        run_txn(1'b0, 32'h10, 32'h0, 3'b010, 2'b01, 0, 1'b0, 1'b0);
        chk("fault_code", 32'(bus.resp_err_code), 32'b001);
        run_txn(1'b0, 32'h10, 32'h0, 3'b010, 2'b00, 3, 1'b1, 1'b1);
        chk("stall_lat", 32'(cap_lat), 32'd5);

        // reset pulse while the access is being issued
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h20;
        bus.req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_pre_r_en", 32'(bus.mem_r_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_r_en", 32'(bus.mem_r_en), 32'd0);
        chk("rst_mid_w_en", 32'(bus.mem_w_en), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | bus.resp_valid;
        end
        chk("rst_no_resp", 32'(seen), 32'd0);
        chk("rst_post_ready", 32'(bus.req_ready), 32'd1);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            r_we = ($urandom % 4 == 0);
            if ($urandom % 5 == 0) r_f3 = 3'($urandom % 8);
            else if (r_we)         r_f3 = 3'($urandom % 3);
            else                   r_f3 = 3'($urandom_range(0, 5) == 3 ? 4 : $urandom_range(0, 2) + ($urandom % 2) * 4);
            if (r_f3 == 3'b110 && !r_we && $urandom % 2 == 0) r_f3 = 3'b010;
            if ($urandom % 10 == 0) r_addr = $urandom;
            else                    r_addr = $urandom_range(0, 4095);
            if ($urandom % 2 == 0)  r_addr = r_addr & ((r_f3[1:0] == 2'b00) ? 32'hFFFF_FFFF :
                                                       (r_f3[1:0] == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            r_fault = (!r_we && $urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(r_we, r_addr, $urandom, r_f3, r_fault,
                    ($urandom % 10 == 0) ? $urandom_range(1, 3) : 0,
                    ($urandom % 3 == 0), ($urandom % 10 == 0));
        end

        // read back a span of memory to confirm stores landed
        for (int i = 0; i < 64; i++)
            run_txn(1'b0, 32'(4 * i), 32'h0, 3'b010, 2'b00, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-aligned data memory. Accepts byte, halfword and word loads/stores at arbitrary byte addresses and checks alignment, bounds and size locally. Legal accesses become single aligned word accesses with byte strobes; load data is lane-extracted and sign/zero-extended. Sits between the execute stage and the `memory` instance and owns the error reporting the memory cannot.

## Interface
- `MEMORY_SIZE_WORDS`, 1024: size of the attached memory in 32-bit words, used for bounds checks.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_enable`  in  1  core run enable; when low, all state holds.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  high only in IDLE; a transfer occurs on an edge with `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_funct3`  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); stores use 000/001/010 only.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err_code`  out  3  000 OK, 001 memory read/write fault, 010 out of bounds, 011 misaligned, 100 illegal size.
- `mem_r_en`, `mem_r_addr[31:0]`, `mem_r_data[31:0]` (in)  read port to memory.
- `mem_w_en`, `mem_w_addr[31:0]`, `mem_w_data[31:0]`, `mem_w_strb[4:0]`  write port to memory.
- `mem_state`  in  2  memory status code, valid after the access edge.

## Operation
- States: IDLE, ISSUE, WAIT, ERR.
- On accept, the block latches `we`, `funct3`, `addr[1:0]` and checks in priority order:
  - illegal funct3: 011, 110, 111, or a store with 1xx → code 100;
  - misaligned: H/HU with `addr[0]`, or W with `addr[1:0]≠0` → code 011;
  - out of bounds: `addr[31:2] >= MEMORY_SIZE_WORDS` → code 010.
  - Any failed check → ERR, and no memory enable is raised.
- Legal access → ISSUE with registered memory outputs:
  - address is `{addr[31:2],2'b00}`;
  - exactly one of `mem_r_en`/`mem_w_en` is high, never both.
- Store lanes:
  - B: data `{4{wdata[7:0]}}`, strobe `4'b0001<<addr[1:0]`;
  - H: data `{2{wdata[15:0]}}`, strobe `4'b0011<<{addr[1],1'b0}`;
  - W: data `wdata`, strobe `4'b1111`;
  - `mem_w_strb[4]` is always 0.
- ISSUE → WAIT unconditionally. Memory enables drop to 0.
- WAIT → IDLE, and `resp_valid` pulses:
  - `mem_state≠00` → code `{1'b0,mem_state}`, rdata 0;
  - otherwise, loads select lane `mem_r_data >> (8*addr[1:0])`, then sign-extend (B/H) or zero-extend (BU/HU).
- ERR → IDLE with the latched code and rdata 0.

## Timing
- Reset (async, immediate) values:
  - state IDLE, `req_ready`=1;
  - `resp_valid`=0, `resp_rdata`=0, `resp_err_code`=000;
  - all `mem_*` outputs 0.
- Legal access: accept at edge E0; memory enable high E0→E1; memory samples at E1; response registered at E2, so `resp_valid` is high for the cycle E2→E3. `req_ready` returns high after E2, so the next accept is at E3 at the earliest.
- Locally rejected access: accept at E0, ERR, `resp_valid` high after E1. Latency is 1.
- `clk_enable` low: no state, output or latch changes, and `resp_valid` holds its level. An edge with `clk_enable` low is not an accept edge.
- `rst_n` asserted mid-transaction: transaction abandoned, no response, memory enables fall asynchronously.
- Requests arriving while `req_ready`=0 are ignored and not queued.

## Test plan
- Memory word[4]=0x8081_F2A3:
  - LB at 0x10 → rdata 0xFFFF_FFA3, code 000, `resp_valid` exactly 2 cycles after accept;
  - LBU at 0x13 → 0x0000_0080.
- Same word:
  - LH at 0x12 → 0xFFFF_8081;
  - LHU at 0x10 → 0x0000_F2A3.
- SB 0x55 at 0x0E:
  - memory sees w_addr 0x0C, w_data 0x5555_5555, strb 0b00100;
  - no read enable during the store.
- Errors, each with no memory enable and response 1 cycle after accept:
  - LW at 0x02 → 011;
  - LH at 0x1001 → 011;
  - LW at 0x1000 (MEMORY_SIZE_WORDS=1024) → 010;
  - funct3=011 → 100.
- `mem_state` forced to 01 during WAIT → code 001, rdata 0.
- `clk_enable` dropped for 3 cycles in WAIT → response delayed 3 cycles, data intact.
- `rst_n` pulsed in ISSUE → enables drop immediately, no `resp_valid`, `req_ready`=1.
